binning_drain: RTL and testbench
================================

Name: binning_drain

Overview:
- Read side of the 8-lane binning buffer. The binning writer deals stream samples round-robin into N lane FIFOs.
- This block waits until every lane holds a full burst, then pops all lanes in lockstep.
- It sums the N co-indexed samples (one binned pixel) and emits the result on a valid/ready stream toward the frame packer.
- Downstream backpressure is absorbed by credit-gated reads and a small output buffer.

Parameters:
- N, 8, number of lanes; power of two, 2..16.
- W, 12, lane sample width.
- BURST, 61, words popped per lane per burst; matches the writer's per-lane block size of 0..60.
- OBUF_DEPTH, 4, output buffer entries; must be at least pipeline depth + 1 (= 3).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- lane_dout  in  N*W  lane i data at bits [i*W +: W]; standard FIFO, 1-cycle read latency.
- lane_empty  in  N  per-lane empty flags.
- lane_prog_full  in  N  per-lane flag: lane holds at least BURST words.
- lane_rd_en  out  1  common pop strobe to all lanes.
- bin_data  out  W+$clog2(N)  binned sum.
- bin_valid  out  1  output valid.
- bin_ready  in  1  downstream ready.
- bin_last  out  1  marks the final word of a burst.
- underflow  out  1  sticky error flag.
- burst_done  out  1  one-cycle pulse when the last word of a burst is accepted downstream.

Behaviour:
- Reset values: lane_rd_en=0, bin_valid=0, bin_data=0, bin_last=0, underflow=0, burst_done=0.
- FSM IDLE -> BURST: in IDLE, when &lane_prog_full=1 for one sampled cycle, load rd_cnt=0 and go to BURST. Level-sensitive, no edge detect.
- BURST read issue: lane_rd_en=1 in a cycle iff credit>0 and rd_cnt<BURST. rd_cnt increments on each issue.
- BURST -> WAIT: when rd_cnt reaches BURST, go to WAIT.
- WAIT -> IDLE: when the word with bin_last=1 is accepted (bin_valid&bin_ready), pulse burst_done and return to IDLE.
- IDLE re-entry rule: the FSM re-checks prog_full no earlier than the cycle after return to IDLE.
- Pipeline stage s1: registered lane capture, the cycle after lane_rd_en.
- Pipeline stage s2: registered adder tree, the sum of N zero-extended W-bit samples at full width W+$clog2(N). No truncation or saturation.
- Latency: lane_rd_en to OBUF write is 2 cycles. If OBUF is empty with bin_ready=1, bin_valid rises 3 cycles after lane_rd_en.
- Credit: credit = OBUF_DEPTH − (obuf_count + in-flight words in s1/s2). A read is never issued without a credit, so OBUF can never overflow.
- bin_last travels with the word issued at rd_cnt==BURST−1.
- Handshake: AXI-stream style. bin_data and bin_last are held stable while bin_valid && !bin_ready. bin_valid never drops without acceptance.
- Full throughput: with bin_ready held high, one word per cycle sustained.
- Underflow: if lane_rd_en=1 while any lane_empty=1, set underflow (sticky until rst). The data still flows; the word is not dropped.
- Stall: bin_ready=0 for an arbitrary time freezes reads once credits are exhausted. No data loss.
- Simultaneous OBUF write and read is supported; count is unchanged.
- Reset mid-burst: all state clears immediately (asynchronous); in-flight words are discarded. Lane FIFO flush is the system's responsibility.

Optional Feature:
- Macro: BINNING_AVG_EN.
- Defined: bin_data width stays W+$clog2(N), but the upper $clog2(N) bits are zero. The low W bits carry the rounded mean, (sum + N/2) >> $clog2(N), computed in s2.
- Not defined: raw sum, as described in Behaviour.

Decomposition:
- Package binning_pkg:
  - constants N_LANES=8, LANE_W=12, BIN_BURST=61;
  - function sum_w(n,w) = w+$clog2(n);
  - enum drain_state_t {IDLE, BURST, WAIT}.
- Sub-module binning_skid_fifo: parameterised synchronous FIFO (DEPTH, WIDTH incl. last bit) with count output. Used as OBUF.

Test Plan:
- Reset, then all lanes hold 61 words with lane i word k = i+k, bin_ready=1 → 61 consecutive outputs. Output k = 8k+28; bin_last only on k=60 (508); burst_done one cycle later; FSM returns to IDLE.
- Same stimulus, bin_ready toggling 1-of-3 cycles → same 61 values in order. Holding stable during stalls is checked. lane_rd_en never pushes obuf_count above 4.
- All lanes at 0xFFF → every output is 0x7FF8 (full width, no overflow). With BINNING_AVG_EN → 0x0FFF. Lane values 1,2,0,0,0,0,0,0 with the macro → (3+4)>>3 = 0.
- Seven lanes prog_full, lane 5 not → no lane_rd_en for 100 cycles. Assert lane 5 → the first lane_rd_en occurs within 2 cycles.
- Force lane_empty[3]=1 during the 10th read → underflow=1 and stays 1 until rst; 61 words are still emitted.
- Assert rst at read 30 of a burst → all outputs are 0 in the same cycle. After release, a new full burst drains cleanly with correct values.

Source files
------------

// File: rtl/binning_pkg.sv
// Shared constants, state encoding and width helper for the binning buffer drain.
package binning_pkg;

    localparam int N_LANES   = 8;
    localparam int LANE_W    = 12;
    localparam int BIN_BURST = 61;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        WAIT  = 2'd2
    } drain_state_t;

    function automatic int sum_w(input int n, input int w);
        return w + $clog2(n);
    endfunction

endpackage

// File: rtl/binning_skid_fifo.sv
// Small synchronous FIFO with occupancy count; the drain uses it as its output buffer.
// Writers must never push into a full buffer; the drain's credit scheme guarantees that.
module binning_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_rd_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign do_rd_s = rd_en_i && (count_q != '0);

    // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (wr_en_i && !do_rd_s) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!wr_en_i && do_rd_s) begin
                count_q <= count_q - CNT_W'(1);
            end else begin
                count_q <= count_q;
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/binning_drain.sv
// Read side of the lane binning buffer: pops all lanes in lockstep, sums co-indexed samples,
// and streams binned pixels out. Define BINNING_AVG_EN to emit the rounded mean instead of the sum.
module binning_drain import binning_pkg::*; #(
    parameter int N          = N_LANES,
    parameter int W          = LANE_W,
    parameter int BURST      = BIN_BURST,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*W-1:0]           lane_dout,
    input  logic [N-1:0]             lane_empty,
    input  logic [N-1:0]             lane_prog_full,
    output logic                     lane_rd_en,
    output logic [sum_w(N, W)-1:0]   bin_data,
    output logic                     bin_valid,
    input  logic                     bin_ready,
    output logic                     bin_last,
    output logic                     underflow,
    output logic                     burst_done
);

    localparam int L   = $clog2(N);
    localparam int SW  = sum_w(N, W);
    localparam int RCW = $clog2(BURST + 1);
    localparam int CW  = $clog2(OBUF_DEPTH + 1);

    localparam logic [RCW-1:0] BURST_C    = RCW'(BURST);
    localparam logic [RCW-1:0] LAST_IDX_C = RCW'(BURST - 1);
    localparam logic [CW:0]    DEPTH_C    = (CW + 1)'(OBUF_DEPTH);

    drain_state_t   state_q, state_d;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
    logic           rd_issue_s;
    logic           s1_valid_q, s1_last_q;
    logic           s2_valid_q, s2_last_q;
    logic [SW-1:0]  s2_data_q, s2_data_d;
    logic [SW-1:0]  sum_s;
    logic [CW-1:0]  obuf_count_s;
    logic [CW:0]    in_use_s;
    logic [SW:0]    obuf_rd_s;
    logic           accept_s;
    logic           underflow_q, burst_done_q;

    // Every OBUF slot already filled or claimed by a word in s1/s2 is unavailable as a credit.
    assign in_use_s = (CW + 1)'(obuf_count_s) + (CW + 1)'(s1_valid_q) + (CW + 1)'(s2_valid_q);
    assign accept_s = bin_valid && bin_ready;

    // State register and per-burst read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= binning_pkg::IDLE;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Next-state: start on a full set of lanes, stop issuing at BURST, finish on the last acceptance.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            binning_pkg::IDLE: begin
                if (&lane_prog_full) begin
                    state_d  = binning_pkg::BURST;
                    rd_cnt_d = '0;
                end else begin
                    state_d  = binning_pkg::IDLE;
                end
            end
            binning_pkg::BURST: begin
                if (rd_cnt_q == BURST_C) begin
                    state_d = binning_pkg::WAIT;
                end else if (rd_issue_s) begin
                    rd_cnt_d = rd_cnt_q + RCW'(1);
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
            end
            binning_pkg::WAIT: begin
                if (accept_s && bin_last) begin
                    state_d = binning_pkg::IDLE;
                end else begin
                    state_d = binning_pkg::WAIT;
                end
            end
            default: begin
                state_d = binning_pkg::IDLE;
            end
        endcase
    end

    // Read issue: only while bursting, with a free credit and words left in the burst.
    always_comb begin
        rd_issue_s = 1'b0;
        case (state_q)
            binning_pkg::BURST: rd_issue_s = (in_use_s < DEPTH_C) && (rd_cnt_q < BURST_C);
            default:            rd_issue_s = 1'b0;
        endcase
    end

    assign lane_rd_en = rd_issue_s;

    // Adder tree over the zero-extended lane samples presented by the lane FIFOs.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = sum_s + SW'(lane_dout[i*W +: W]);
        end
    end

`ifdef BINNING_AVG_EN
    localparam logic [SW-1:0] HALF_C = SW'(N / 2);
    assign s2_data_d = (sum_s + HALF_C) >> L;
`else
    assign s2_data_d = sum_s;
`endif

    // s1 marks the cycle the popped samples sit on lane_dout; s2 registers the reduced word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_issue_s;
            s1_last_q  <= rd_issue_s && (rd_cnt_q == LAST_IDX_C);
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_data_q  <= s1_valid_q ? s2_data_d : s2_data_q;
        end
    end

    binning_skid_fifo #(
        .DEPTH (OBUF_DEPTH),
        .WIDTH (SW + 1)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (s2_valid_q),
        .wr_data_i ({s2_last_q, s2_data_q}),
        .rd_en_i   (bin_ready),
        .rd_data_o (obuf_rd_s),
        .count_o   (obuf_count_s)
    );

    assign bin_valid = (obuf_count_s != '0);
    assign bin_data  = obuf_rd_s[SW-1:0];
    assign bin_last  = obuf_rd_s[SW];

    // Sticky underflow and end-of-burst pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q  <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            underflow_q  <= underflow_q | (rd_issue_s & (|lane_empty));
            burst_done_q <= accept_s & bin_last;
        end
    end

    assign underflow  = underflow_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_binning_drain.sv
// Randomised scoreboard bench for binning_drain: lane FIFO model, reference sums, stream monitor.
module tb_binning_drain;

    localparam int N     = 8;
    localparam int W     = 12;
    localparam int LG    = 3;
    localparam int SW    = W + LG;
    localparam int BURST = 61;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] lane_dout;
    logic [N-1:0]   lane_empty, lane_prog_full;
    logic           lane_rd_en, bin_valid, bin_ready, bin_last, underflow, burst_done;
    logic [SW-1:0]  bin_data;

    logic [W-1:0]   lq [N][$];
    logic [W-1:0]   dout_r [N] = '{default: '0};
    logic [N-1:0]   empty_r = '1;
    logic [N-1:0]   pf_r = '0;
    logic [N-1:0]   pf_mask, empty_force;
    logic [SW:0]    exp_q [$];
    logic [SW:0]    e;

    int n_pass = 0, n_total = 0;
    int issued = 0, accepted = 0, done_cnt = 0;
    int rdy_mode = 0;
    logic rd_s = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0, prev_acc_last = 1'b0;
    logic [SW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    binning_drain dut (
        .clk            (clk),
        .rst            (rst),
        .lane_dout      (lane_dout),
        .lane_empty     (lane_empty),
        .lane_prog_full (lane_prog_full),
        .lane_rd_en     (lane_rd_en),
        .bin_data       (bin_data),
        .bin_valid      (bin_valid),
        .bin_ready      (bin_ready),
        .bin_last       (bin_last),
        .underflow      (underflow),
        .burst_done     (burst_done)
    );

    assign lane_empty     = empty_r | empty_force;
    assign lane_prog_full = pf_r & pf_mask;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_dout[i*W +: W] = dout_r[i];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_le(input string name, input longint act, input longint lim);
        n_total++;
        if (act <= lim) n_pass++;
        else $display("FAIL %s: got %0d required <= %0d", name, act, lim);
    endtask

    // Lane FIFO model: one-cycle read latency, flags reflect contents after the edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_s && lq[i].size() > 0) dout_r[i] <= lq[i].pop_front();
            empty_r[i] <= (lq[i].size() == 0);
            pf_r[i]    <= (lq[i].size() >= BURST);
        end
    end

    // Fill every lane with one burst and queue the binned words a correct drain must emit.
    task automatic load_burst(input int mode);
        for (int k = 0; k < BURST; k++) begin
            int sum;
            int v;
            sum = 0;
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0:       v = i + k;
                    1:       v = 4095;
                    2:       v = int'($urandom_range(0, 4095));
                    default: v = (i == 0) ? 1 : ((i == 1) ? 2 : 0);
                endcase
                lq[i].push_back(W'(v));
                sum += v;
            end
`ifdef BINNING_AVG_EN
            sum = (sum + N / 2) / N;
`endif
            exp_q.push_back({(k == BURST - 1), SW'(sum)});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Stream monitor: scoreboard pops, hold-while-stalled, burst_done timing, in-flight bound.
    always @(negedge clk) begin
        #1;
        rd_s = lane_rd_en;
        if (rst) begin
            issued        = 0;
            accepted      = 0;
            prev_stall    = 1'b0;
            prev_acc_last = 1'b0;
        end else begin
            check("burst_done", longint'(burst_done), longint'(prev_acc_last));
            if (prev_stall) begin
                check("hold_valid", longint'(bin_valid), 1);
                check("hold_data", longint'(bin_data), longint'(prev_data));
                check("hold_last", longint'(bin_last), longint'(prev_last));
            end
            if (lane_rd_en) begin
                issued++;
                check_le("inflight", issued - accepted, 4);
            end
            if (bin_valid && bin_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got data %0d with nothing expected", bin_data);
                end else begin
                    e = exp_q.pop_front();
                    check("bin_data", longint'(bin_data), longint'(e[SW-1:0]));
                    check("bin_last", longint'(bin_last), longint'(e[SW]));
                end
                accepted++;
            end
            if (burst_done) done_cnt++;
            prev_acc_last = bin_valid && bin_ready && bin_last;
            prev_stall    = bin_valid && !bin_ready;
            prev_data     = bin_data;
            prev_last     = bin_last;
        end
    end

    // Downstream ready pattern: always, one cycle in three, or random.
    initial begin
        int phase;
        phase = 0;
        bin_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0: bin_ready = 1'b1;
                1: begin
                    phase = (phase + 1) % 3;
                    bin_ready = (phase == 0);
                end
                default: bin_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, longint'(lane_rd_en), 0);
        check({tag, "_valid"}, longint'(bin_valid), 0);
        check({tag, "_data"}, longint'(bin_data), 0);
        check({tag, "_last"}, longint'(bin_last), 0);
        check({tag, "_underflow"}, longint'(underflow), 0);
        check({tag, "_burst_done"}, longint'(burst_done), 0);
    endtask

    initial begin
        int n, m, cnt, base, exp_done;
        exp_done    = 0;
        rst         = 1'b1;
        pf_mask     = '1;
        empty_force = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp pattern, ready high: first-word latency and 8k+28 sequence.
        load_burst(0);
        n = 0;
        while (!lane_rd_en && n < 20) begin @(negedge clk); n++; end
        check("rd_start", longint'(lane_rd_en), 1);
        m = 0;
        while (!bin_valid && m < 10) begin @(negedge clk); m++; end
        check("latency", m, 3);
        drain();
        exp_done++;
        check("burst_done_count", done_cnt, exp_done);

        // Same ramp, ready one cycle in three.
        rdy_mode = 1;
        load_burst(0);
        drain();
        exp_done++;
        check("burst_done_count", done_cnt, exp_done);

        // Saturated lanes and random data under random backpressure.
        rdy_mode = 2;
        load_burst(1);
        drain();
        load_burst(2);
        drain();
        load_burst(3);
        drain();
        exp_done += 3;
        check("burst_done_count", done_cnt, exp_done);

        // Lane 5 withholds prog_full: no reads until it rises.
        rdy_mode = 0;
        pf_mask  = 8'hDF;
        load_burst(2);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (lane_rd_en) cnt++;
        end
        check("rd_while_lane5_low", cnt, 0);
        pf_mask = '1;
        n = 0;
        while (!lane_rd_en && n < 10) begin @(negedge clk); n++; end
        check_le("rd_after_release", n, 2);
        drain();
        exp_done++;
        check("burst_done_count", done_cnt, exp_done);

        // Lane 3 reports empty during the tenth read.
        check("underflow_before", longint'(underflow), 0);
        base = issued;
        load_burst(0);
        n = 0;
        while ((issued - base) != 9 && n < 200) begin @(negedge clk); n++; end
        check("tenth_read_issued", longint'(lane_rd_en), 1);
        empty_force = 8'h08;
        @(negedge clk);
        empty_force = '0;
        @(negedge clk);
        check("underflow_set", longint'(underflow), 1);
        drain();
        exp_done++;
        check("burst_done_count", done_cnt, exp_done);
        check("underflow_sticky", longint'(underflow), 1);

        // Reset at read 30, then a clean burst.
        base = issued;
        load_burst(0);
        n = 0;
        while ((issued - base) != 30 && n < 200) begin @(negedge clk); n++; end
        rst = 1'b1;
        #2;
        check_all_zero("midreset");
        for (int i = 0; i < N; i++) lq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load_burst(0);
        drain();
        exp_done++;
        check("burst_done_count", done_cnt, exp_done);
        check("underflow_after_reset", longint'(underflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
